// File: rtl/lu_pkg.sv
// Shared constants and enumerations for the shared bitwise logic unit and its arbiter.
package lu_pkg;

  localparam int unsigned LU_WIDTH = 16;
  localparam int unsigned LU_OPW   = 2;

  typedef enum logic [LU_OPW-1:0] {
    LU_OR  = 2'b00,
    LU_AND = 2'b01,
    LU_XOR = 2'b10,
    LU_NOR = 2'b11
  } lu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } lu_state_e;

endpackage

// File: rtl/lu_bitwise.sv
// Combinational 16-bit bitwise logic unit: OR / AND / XOR / NOR, no carry or extension.
module lu_bitwise
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = LU_WIDTH
) (
  input  lu_op_e             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = '0;
    unique case (op)
      LU_OR:  y = a | b;
      LU_AND: y = a & b;
      LU_XOR: y = a ^ b;
      LU_NOR: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-port round-robin front end for one shared bitwise logic unit: accept, execute, hold result.
// Optional build macro LU_STATS_EN adds a 16-bit completed-operation counter on port op_count.
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = LU_WIDTH,
  parameter int unsigned OPW   = LU_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_zero
`ifdef LU_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  lu_state_e        state_q, state_d;
  logic             last_id_q, last_id_d;
  lu_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             any_valid;
  logic             gnt_id;
  logic [WIDTH-1:0] lu_y;

  lu_bitwise #(.WIDTH(WIDTH)) u_bitwise (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y)
  );

  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_zero_d = rsp_zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    any_valid = req0_valid | req1_valid;
    // On a tie the requester that did not win last time goes first.
    gnt_id    = (req0_valid & req1_valid) ? ~last_id_q : req1_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (any_valid && !rst) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          op_d       = gnt_id ? lu_op_e'(req1_op) : lu_op_e'(req0_op);
          a_d        = gnt_id ? req1_a : req0_a;
          b_d        = gnt_id ? req1_b : req0_b;
          id_d       = gnt_id;
          last_id_d  = gnt_id;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d = lu_y;
        rsp_zero_d = (lu_y == '0);
        rsp_id_d   = id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_id_q  <= 1'b1;
      op_q       <= LU_OR;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_zero  = rsp_zero_q;

`ifdef LU_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (rsp_valid && rsp_ready) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed cases plus randomized traffic against a transaction model.
module tb_logic_unit_arbiter;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_op = '0, req1_op = '0;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          rsp_id, rsp_zero;
`ifdef LU_STATS_EN
  logic [15:0]   op_count;
`endif

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(16), .OPW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_zero   (rsp_zero)
`ifdef LU_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] lu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Transaction model: who may be accepted, and what the result must be and when.
  typedef struct {
    logic [15:0] data;
    logic        id;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic        grant_log[$];
  logic        m_last = 1'b1;
  logic        m_busy = 1'b0;
  int          cyc = 0;
  int          n_hs = 0;
  logic        taken0 = 1'b0, taken1 = 1'b0;
  logic [15:0] last_data = '0;
  logic        last_rid = 1'b0, last_zero = 1'b0;
  logic [1:0]  exp_rdy;
  logic        g;
  logic        exp_vld;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      exp_q.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      exp_rdy = 2'b00;
      g       = 1'b0;
      if (!m_busy && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) g = !m_last;
        else                          g = req1_valid;
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
      exp_vld = m_busy && (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_vld});
      if (exp_vld && rsp_valid) begin
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_q[0].data});
        chk("rsp_id",   {31'd0, rsp_id},   {31'd0, exp_q[0].id});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, (exp_q[0].data == 16'd0)});
      end
      if (exp_vld && rsp_ready) begin
        last_data = rsp_data;
        last_rid  = rsp_id;
        last_zero = rsp_zero;
        void'(exp_q.pop_front());
        m_busy = 1'b0;
        n_hs++;
      end
      if (exp_rdy != 2'b00) begin
        e.data = g ? lu_ref(req1_op, req1_a, req1_b) : lu_ref(req0_op, req0_a, req0_b);
        e.id   = g;
        e.acc  = cyc;
        exp_q.push_back(e);
        grant_log.push_back(g);
        m_last = g;
        m_busy = 1'b1;
        if (g) taken1 = 1'b1;
        else   taken0 = 1'b1;
      end
    end
  end

  logic auto0 = 1'b0, auto1 = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (taken0) begin
      taken0 = 1'b0;
      if (auto0) begin
        req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom); req0_b = 16'($urandom);
      end else req0_valid = 1'b0;
    end
    if (taken1) begin
      taken1 = 1'b0;
      if (auto1) begin
        req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom); req1_b = 16'($urandom);
      end else req1_valid = 1'b0;
    end
  endtask

  task automatic set_req(input logic p, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (p) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else   begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
  endtask

  task automatic wait_grants(input int n);
    int target;
    target = grant_log.size() + n;
    for (int i = 0; i < 60 && grant_log.size() < target; i++) step();
    if (grant_log.size() < target) chk("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int k;
    rsp_ready = 1'b1;
    auto0 = 1'b0;
    auto1 = 1'b0;
    k = 0;
    while (k < 80 && (req0_valid || req1_valid || m_busy)) begin
      step();
      k++;
    end
    if (req0_valid || req1_valid || m_busy) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic p, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] expd, input logic expz);
    int h;
    rsp_ready = 1'b1;
    h = n_hs;
    set_req(p, op, a, b);
    for (int i = 0; i < 30 && n_hs == h; i++) step();
    if (n_hs == h) chk({tag, "_timeout"}, 32'd1, 32'd0);
    chk({tag, "_data"}, {16'd0, last_data}, {16'd0, expd});
    chk({tag, "_id"},   {31'd0, last_rid},  {31'd0, p});
    chk({tag, "_zero"}, {31'd0, last_zero}, {31'd0, expz});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int gl;
    step();
    step();
    rst = 1'b0;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data",  {16'd0, rsp_data},  32'd0);
    chk("reset_rsp_id",    {31'd0, rsp_id},    32'd0);
    chk("reset_rsp_zero",  {31'd0, rsp_zero},  32'd0);

    run_op("or",    1'b0, 2'd0, 16'hFFFE, 16'hFFDE, 16'hFFFE, 1'b0);
    run_op("and",   1'b0, 2'd1, 16'hFFFE, 16'hFFDE, 16'hFFDE, 1'b0);
    run_op("xor",   1'b0, 2'd2, 16'hFFFE, 16'hFFDE, 16'h0020, 1'b0);
    run_op("nor",   1'b0, 2'd3, 16'hFFFE, 16'hFFDE, 16'h0001, 1'b0);
    run_op("xor_f", 1'b1, 2'd2, 16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b0);
    run_op("nor_z", 1'b1, 2'd3, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b1);

    // Contention: last winner was port 1, so the alternation starts at port 0.
    rsp_ready = 1'b1;
    auto0 = 1'b1;
    auto1 = 1'b1;
    set_req(1'b0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    set_req(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
    gl = grant_log.size();
    wait_grants(4);
    for (int i = 0; i < 4; i++) begin
      if (gl + i < grant_log.size()) chk("contend_order", {31'd0, grant_log[gl + i]}, i % 2);
    end
    drain();

    // Backpressure: result held 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    set_req(1'b0, 2'd1, 16'h1234, 16'h00FF);
    wait_grants(1);
    set_req(1'b1, 2'd0, 16'h0001, 16'h0002);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data",  {16'd0, rsp_data},  32'h0034);
      chk("bp_id",    {31'd0, rsp_id},    32'd0);
      chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req1_ready}, 32'd1);
    drain();

    // Reset while the operation is in EXEC.
    rsp_ready = 1'b0;
    set_req(1'b1, 2'd0, 16'hAAAA, 16'h5555);
    wait_grants(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_data",  {16'd0, rsp_data},  32'd0);
    set_req(1'b0, 2'd2, 16'h00F0, 16'h0FF0);
    set_req(1'b1, 2'd2, 16'h1111, 16'h2222);
    gl = grant_log.size();
    wait_grants(1);
    if (gl < grant_log.size()) chk("rstmid_tie", {31'd0, grant_log[gl]}, 32'd0);
    drain();

    // Randomized traffic with random backpressure and occasional zero results.
    for (int i = 0; i < 400; i++) begin
      step();
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_op = 2'($urandom_range(0, 3)); req0_a = 16'($urandom);
        req0_b = ($urandom_range(0, 5) == 0) ? req0_a : 16'($urandom);
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_op = 2'($urandom_range(0, 3)); req1_a = 16'($urandom);
        req1_b = ($urandom_range(0, 5) == 0) ? req1_a : 16'($urandom);
        req1_valid = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    drain();

`ifdef LU_STATS_EN
    pulse_reset();
    run_op("st1", 1'b0, 2'd0, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    run_op("st2", 1'b1, 2'd1, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
    run_op("st3", 1'b0, 2'd2, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1);
    step();
    chk("op_count_3", {16'd0, op_count}, 32'd3);
    pulse_reset();
    chk("op_count_rst", {16'd0, op_count}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
